fractal_sync_merge_ctrl: RTL

Pairing controller between the left and right rx request FIFOs of a fractal synchronization node and the node's single upward tx path. It inspects both FIFO heads and pops matching barrier requests together, emitting one merged request. Unmatched heads are forwarded alone after a bounded wait or by round-robin arbitration. The output is a one-entry registered valid/ready stage.

---
 rtl/fractal_sync_merge_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_merge_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fractal_sync_merge_ctrl
// Brief    : Pairs left/right rx FIFO heads into merged barrier requests for the
//            upward tx path. Lone-head timeout enabled by
//            FRACTAL_SYNC_MERGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

package fractal_sync_merge_pkg;
    typedef struct packed {
        logic [2:0] aggr;
        logic [3:0] id;
    } fsync_sig_t;

    typedef struct packed {
        logic       sync;
        fsync_sig_t sig;
        logic [1:0] src;
    } fsync_req_t;
endpackage

module fractal_sync_merge_ctrl #(
    parameter type fsync_req_t = fractal_sync_merge_pkg::fsync_req_t,
    parameter int  WAIT_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       l_empty_i,
    input  fsync_req_t l_req_i,
    output logic       l_pop_o,
    input  logic       r_empty_i,
    input  fsync_req_t r_req_i,
    output logic       r_pop_o,
    output fsync_req_t req_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       error_aggr_o
);

    if (WAIT_CYCLES <= 0) begin : g_bad_wait_cycles
        $fatal(1, "fractal_sync_merge_ctrl: WAIT_CYCLES must be > 0");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_prio;
    logic       w_prio_nxt;
    fsync_req_t r_req;
    fsync_req_t w_req_nxt;
    fsync_req_t w_merged;
    logic       w_l_vld;
    logic       w_r_vld;
    logic       w_l_pop;
    logic       w_r_pop;
    logic       w_err;

`ifdef FRACTAL_SYNC_MERGE_TIMEOUT_EN
    localparam int              CNT_W   = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    fsync_req_t       w_lone;

    assign w_lone = w_l_vld ? l_req_i : r_req_i;
`endif

    assign w_l_vld = !l_empty_i;
    assign w_r_vld = !r_empty_i;

    // Merged request keeps the left aggr/id and unions the source bits.
    always_comb begin
        w_merged      = l_req_i;
        w_merged.sync = 1'b1;
        w_merged.src  = l_req_i.src | r_req_i.src;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        w_req_nxt   = r_req;
        w_l_pop     = 1'b0;
        w_r_pop     = 1'b0;
        w_err       = 1'b0;
`ifdef FRACTAL_SYNC_MERGE_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
        unique case (r_state)
            S_IDLE, S_WAIT: begin
                if (w_l_vld && w_r_vld) begin
                    w_state_nxt = S_SEND;
                    if (l_req_i.sig.id == r_req_i.sig.id) begin
                        w_l_pop   = 1'b1;
                        w_r_pop   = 1'b1;
                        w_req_nxt = w_merged;
                        w_err     = (l_req_i.sig.aggr != r_req_i.sig.aggr);
                    end else if (!r_prio) begin
                        w_l_pop    = 1'b1;
                        w_req_nxt  = l_req_i;
                        w_prio_nxt = 1'b1;
                    end else begin
                        w_r_pop    = 1'b1;
                        w_req_nxt  = r_req_i;
                        w_prio_nxt = 1'b0;
                    end
                end else if (w_l_vld || w_r_vld) begin
                    if (r_state == S_IDLE) begin
                        w_state_nxt = S_WAIT;
                    end else begin
`ifdef FRACTAL_SYNC_MERGE_TIMEOUT_EN
                        if (r_cnt == CNT_MAX) begin
                            w_l_pop     = w_l_vld;
                            w_r_pop     = w_r_vld;
                            w_req_nxt   = w_lone;
                            w_state_nxt = S_SEND;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
`endif
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Combinational pops must stay quiet while reset is held.
        if (!rst_ni) begin
            w_l_pop = 1'b0;
            w_r_pop = 1'b0;
            w_err   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_req   <= w_req_nxt;
        end
    end

`ifdef FRACTAL_SYNC_MERGE_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign l_pop_o      = w_l_pop;
    assign r_pop_o      = w_r_pop;
    assign error_aggr_o = w_err;
    assign valid_o      = (r_state == S_SEND);
    assign req_o        = r_req;

endmodule

`default_nettype wire
